// File: rtl/mul_pkg.sv
// Shared types and constants for the multicycle multiplier result stage.
//   state_e               : sequencer states (IDLE, SETTLE, HOLD)
//   WORD_W / PROD_W       : operand and product widths
//   DEFAULT_SETTLE_CYCLES : default cycles the operands are held before sampling
package mul_pkg;

    localparam int unsigned WORD_W                = 32;
    localparam int unsigned PROD_W                = 64;
    localparam int unsigned DEFAULT_SETTLE_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_e;

endpackage

// File: rtl/booth.sv
// Combinational 32x32 signed radix-4 Booth multiplier.
//   a, b     : signed two's complement operands
//   Zlowout  : product[31:0]
//   Zhighout : product[63:32]
module booth (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] Zlowout,
    output logic [31:0] Zhighout
);

    logic [32:0] b_ext;
    logic [63:0] a_ext;
    logic [63:0] pp;
    logic [63:0] acc;
    logic [2:0]  sel;

    always_comb begin
        b_ext = {b, 1'b0};
        a_ext = {{32{a[31]}}, a};
        acc   = '0;
        pp    = '0;
        sel   = '0;
        // Each overlapping 3-bit window of b selects a digit in {-2,-1,0,1,2}.
        for (int i = 0; i < 16; i++) begin
            sel = b_ext[2*i +: 3];
            case (sel)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        Zlowout  = acc[31:0];
        Zhighout = acc[63:32];
    end

endmodule

// File: rtl/mul_result_stage.sv
// Multicycle sequencer and result register stage around the booth multiplier.
// Operands are latched on an accepted start and held for SETTLE_CYCLES cycles, then the
// 64-bit product and its zero/overflow flags are registered and offered with done/ack.
//   clock, clear        : clock and synchronous active-high reset
//   start, a_in, b_in   : request and signed operands, sampled only when accepting
//   ack                 : consumer takes the result while done=1
//   busy, done          : operands settling / result valid
//   zhigh_out, zlow_out : registered product[63:32] / product[31:0]
//   zero, ovf           : registered product==0 / product does not fit in signed 32 bits
module mul_result_stage
    import mul_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int unsigned CNT_W         = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [WORD_W-1:0] a_in,
    input  logic [WORD_W-1:0] b_in,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] zhigh_out,
    output logic [WORD_W-1:0] zlow_out,
    output logic              zero,
    output logic              ovf
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] a_q, a_d, b_q, b_d;
    logic [WORD_W-1:0] zhigh_q, zhigh_d, zlow_q, zlow_d;
    logic              zero_q, zero_d, ovf_q, ovf_d;
    logic [WORD_W-1:0] prod_lo, prod_hi;
    logic              accept;

    // Multiplier only ever sees the held operands, so a_in/b_in may change freely.
    booth u_booth (
        .a        (a_q),
        .b        (b_q),
        .Zlowout  (prod_lo),
        .Zhighout (prod_hi)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        zhigh_d = zhigh_q;
        zlow_d  = zlow_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        accept  = (state_q == IDLE) || ((state_q == HOLD) && ack);

        case (state_q)
            IDLE: begin
                if (start) state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    zhigh_d = prod_hi;
                    zlow_d  = prod_lo;
                    zero_d  = (prod_hi == '0) && (prod_lo == '0);
                    ovf_d   = prod_hi != {WORD_W{prod_lo[WORD_W-1]}};
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ack) state_d = start ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Shared by IDLE and the back-to-back HOLD path.
        if (accept && start) begin
            a_d   = a_in;
            b_d   = b_in;
            cnt_d = CntLoad;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            zhigh_q <= '0;
            zlow_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            zhigh_q <= zhigh_d;
            zlow_q  <= zlow_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == SETTLE);
    assign done      = (state_q == HOLD);
    assign zhigh_out = zhigh_q;
    assign zlow_out  = zlow_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mul_result_stage.sv
module tb_mul_result_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance 0: default SETTLE_CYCLES=2. Instance 1: SETTLE_CYCLES=1.
    logic        clear0, start0, ack0, busy0, done0, zero0, ovf0;
    logic [31:0] a0, b0, zh0, zl0;
    logic        clear1, start1, ack1, busy1, done1, zero1, ovf1;
    logic [31:0] a1, b1, zh1, zl1;

    mul_result_stage u_dut0 (
        .clock(clock), .clear(clear0), .start(start0), .a_in(a0), .b_in(b0), .ack(ack0),
        .busy(busy0), .done(done0), .zhigh_out(zh0), .zlow_out(zl0), .zero(zero0), .ovf(ovf0)
    );

    mul_result_stage #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (
        .clock(clock), .clear(clear1), .start(start1), .a_in(a1), .b_in(b1), .ack(ack1),
        .busy(busy1), .done(done1), .zhigh_out(zh1), .zlow_out(zl1), .zero(zero1), .ovf(ovf1)
    );

    int nchecks = 0;
    int nerrors = 0;
    int which   = 0;

    typedef struct {
        logic [31:0] a, b, hi, lo;
        logic        z, o;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // busy and done must never be high together.
    always @(negedge clock) begin
        if (!clear0) begin
            nchecks++;
            if (busy0 && done0) begin
                nerrors++;
                $display("FAIL busy_done_excl0: got busy=1 done=1 expected not both");
            end
        end
        if (!clear1) begin
            nchecks++;
            if (busy1 && done1) begin
                nerrors++;
                $display("FAIL busy_done_excl1: got busy=1 done=1 expected not both");
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic ak, input logic [31:0] a, input logic [31:0] b);
        if (which == 0) begin
            start0 = st; ack0 = ak; a0 = a; b0 = b;
        end else begin
            start1 = st; ack1 = ak; a1 = a; b1 = b;
        end
    endtask

    task automatic rd(output logic bz, output logic dn, output logic [31:0] h, output logic [31:0] l,
                      output logic z, output logic o);
        if (which == 0) begin
            bz = busy0; dn = done0; h = zh0; l = zl0; z = zero0; o = ovf0;
        end else begin
            bz = busy1; dn = done1; h = zh1; l = zl1; z = zero1; o = ovf1;
        end
    endtask

    // Reference: full signed product by plain 64-bit arithmetic; overflow by range test.
    task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] hi,
                         output logic [31:0] lo, output logic z, output logic o);
        longint p, maxv, minv;
        p    = longint'($signed(a)) * longint'($signed(b));
        maxv = 64'sh7FFF_FFFF;
        minv = -maxv - 1;
        hi   = p[63:32];
        lo   = p[31:0];
        z    = (p == 0);
        o    = (p > maxv) || (p < minv);
    endtask

    // One complete operation from IDLE with ack held high; returns observed result.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, output logic [31:0] h, output logic [31:0] l,
                          output logic z, output logic o);
        logic bz, dn, eh_z, eo;
        logic [31:0] eh, el;
        int n;
        which = sel;
        drive(1'b1, 1'b1, a, b);
        step();
        drive(1'b0, 1'b1, 32'hA5A5_5A5A, 32'h0F0F_F0F0);
        rd(bz, dn, h, l, z, o);
        chk("busy_after_start", bz, 1);
        n = 0;
        while (!dn && n < 20) begin
            step();
            n++;
            rd(bz, dn, h, l, z, o);
        end
        chk("latency", n, exp_lat);
        chk("done_busy_low", bz, 0);
        model(a, b, eh, el, eh_z, eo);
        chk("zhigh", h, eh);
        chk("zlow", l, el);
        chk("zero", z, eh_z);
        chk("ovf", o, eo);
        step();
        drive(1'b0, 1'b0, a, b);
        rd(bz, dn, h, l, z, o);
        chk("idle_done", dn, 0);
        chk("idle_busy", bz, 0);
        chk("idle_keep_lo", l, el);
    endtask

    logic [31:0] h, l, eh, el;
    logic        z, o, ez, eo, bz, dn;
    logic [31:0] ra, rb;
    logic [31:0] extremes[4];
    int          n;

    initial begin
        vecs[0] = '{32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0, 1'b1};
        vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0,         1'b0, 1'b1};
        vecs[3] = '{32'h1234_5678, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0, 1'b0};
        vecs[5] = '{32'd5,         32'd6,         32'h0,         32'd30,        1'b0, 1'b0};
        extremes[0] = 32'h8000_0000; extremes[1] = 32'h7FFF_FFFF;
        extremes[2] = 32'hFFFF_FFFF; extremes[3] = 32'h0;

        clear0 = 1; start0 = 0; ack0 = 0; a0 = 0; b0 = 0;
        clear1 = 1; start1 = 0; ack1 = 0; a1 = 0; b1 = 0;
        step(); step();
        clear0 = 0; clear1 = 0;
        which = 0;
        rd(bz, dn, h, l, z, o);
        chk("rst_busy", bz, 0); chk("rst_done", dn, 0); chk("rst_zhigh", h, 0);
        chk("rst_zlow", l, 0);  chk("rst_zero", z, 0);  chk("rst_ovf", o, 0);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, 2, h, l, z, o);
            chk("tbl_hi", h, vecs[i].hi); chk("tbl_lo", l, vecs[i].lo);
            chk("tbl_zero", z, vecs[i].z); chk("tbl_ovf", o, vecs[i].o);
        end

        // Operand changes and a start pulse during SETTLE are ignored.
        which = 0;
        drive(1, 0, 32'h1234_5678, 32'h0); step();
        drive(1, 0, 32'hDEAD_BEEF, 32'hBEEF_0001); step();
        drive(0, 0, 32'hDEAD_BEEF, 32'hBEEF_0001);
        n = 0; rd(bz, dn, h, l, z, o);
        while (!dn && n < 20) begin step(); n++; rd(bz, dn, h, l, z, o); end
        chk("settle_ign_lat", n, 1);
        chk("settle_ign_hi", h, 0); chk("settle_ign_lo", l, 0); chk("settle_ign_zero", z, 1);
        drive(0, 1, 0, 0); step(); drive(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            rd(bz, dn, h, l, z, o);
            chk("no_second_op", {bz, dn}, 2'b00);
            step();
        end

        // HOLD without ack: stable outputs, start ignored; then back-to-back accept.
        drive(1, 0, 32'h0000_1234, 32'hFFFF_5678); step();
        drive(0, 0, 0, 0);
        n = 0; rd(bz, dn, h, l, z, o);
        while (!dn && n < 20) begin step(); n++; rd(bz, dn, h, l, z, o); end
        model(32'h0000_1234, 32'hFFFF_5678, eh, el, ez, eo);
        for (int k = 0; k < 5; k++) begin
            drive(logic'(k % 2), 0, $urandom, $urandom); step();
            rd(bz, dn, h, l, z, o);
            chk("hold_done", dn, 1); chk("hold_hi", h, eh); chk("hold_lo", l, el);
        end
        drive(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
        drive(0, 0, 0, 0);
        rd(bz, dn, h, l, z, o);
        chk("b2b_done_drop", dn, 0); chk("b2b_busy", bz, 1);
        step(); rd(bz, dn, h, l, z, o); chk("b2b_e1_done", dn, 0);
        step(); rd(bz, dn, h, l, z, o);
        chk("b2b_e2_done", dn, 1); chk("b2b_hi", h, 0); chk("b2b_lo", l, 1);
        drive(0, 1, 0, 0); step(); drive(0, 0, 0, 0);

        // clear mid-SETTLE discards the operation.
        drive(1, 0, 32'd9, 32'd9); step();
        drive(0, 0, 0, 0); step();
        clear0 = 1; step(); clear0 = 0;
        rd(bz, dn, h, l, z, o);
        chk("clr_busy", bz, 0); chk("clr_done", dn, 0); chk("clr_hi", h, 0);
        chk("clr_lo", l, 0); chk("clr_zero", z, 0); chk("clr_ovf", o, 0);
        for (int k = 0; k < 4; k++) begin
            step(); rd(bz, dn, h, l, z, o); chk("clr_no_done", dn, 0);
        end
        run_op(0, 32'd5, 32'd6, 2, h, l, z, o);
        chk("after_clr_lo", l, 30);

        // Randomized operations against the reference.
        for (int i = 0; i < 30; i++) begin
            ra = (i % 5 == 0) ? extremes[$urandom_range(0, 3)] : $urandom;
            rb = (i % 7 == 0) ? extremes[$urandom_range(0, 3)] : $urandom;
            run_op(0, ra, rb, 2, h, l, z, o);
        end

        // SETTLE_CYCLES=1 instance.
        run_op(1, 32'hFFFF_FFF8, 32'd4, 1, h, l, z, o);
        chk("sc1_hi", h, 32'hFFFF_FFFF); chk("sc1_lo", l, 32'hFFFF_FFE0);
        for (int i = 0; i < 8; i++) run_op(1, $urandom, $urandom, 1, h, l, z, o);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
